// File: rtl/mc_control.sv
// mc_control: multicycle Moore controller for the final_core MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, drives every datapath
// select and write enable, and decodes op/funct into the 3-bit ALU control.
module mc_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       regdst,
    output logic       memtoreg,
    output logic       iord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       pcen,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        AOP_ADD,
        AOP_SUB,
        AOP_FUNCT
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q, state_d;
    state_t dec_state;
    aluop_t aluop;
    logic   pcwrite, branch;
    logic   irwrite_raw, memwrite_raw, regwrite_raw;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // While in reset the outputs decode as FETCH regardless of the held state.
    assign dec_state = rst_n ? state_q : S_FETCH;

    // Moore output decode of the (reset-qualified) state.
    always_comb begin
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        iord         = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        aluop        = AOP_ADD;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        case (dec_state)
            S_FETCH: begin
                irwrite_raw = 1'b1;
                alusrcb     = 2'b01;
                pcwrite     = 1'b1;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                regwrite_raw = 1'b1;
                memtoreg     = 1'b1;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = AOP_FUNCT;
            end
            S_ALUWB: begin
                regwrite_raw = 1'b1;
                regdst       = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = AOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB: regwrite_raw = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder.
    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            AOP_SUB:   alucontrol = 3'b110;
            AOP_FUNCT: begin
                case (funct)
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default:   alucontrol = 3'b010;
        endcase
    end

    assign irwrite  = rst_n & irwrite_raw;
    assign memwrite = rst_n & memwrite_raw;
    assign regwrite = rst_n & regwrite_raw;
    assign pcen     = rst_n & (pcwrite | (branch & zero));
    assign state    = state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: scoreboard bench for mc_control. A driver issues whole
// instructions (directed then random), pushing the expected control word of
// every cycle into a queue; a monitor pops and compares each cycle.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       zero;
    logic       regdst, memtoreg, iord, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       irwrite, memwrite, regwrite, pcen;
    logic [3:0] state;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [18:0] sb_q[$];

    mc_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .regdst(regdst), .memtoreg(memtoreg), .iord(iord), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .pcen(pcen), .state(state)
    );

    always #5 clk = ~clk;

    // Reference ALU control for an R-type funct field.
    function automatic logic [2:0] funct_ctl(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected control word {state, regdst, memtoreg, iord, alusrca, alusrcb,
    // pcsrc, alucontrol, irwrite, memwrite, regwrite, pcen} for one cycle.
    function automatic logic [18:0] exp_word(input logic [3:0] s, input logic in_rst,
                                              input logic [5:0] f, input logic z);
        logic rd, mr, io, sa, irw, mw, rw, pe;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {rd, mr, io, sa, irw, mw, rw, pe} = '0;
        sb = 2'b00; ps = 2'b00; ac = 3'b010;
        if (in_rst) sb = 2'b01;
        else begin
            case (s)
                4'd0:  begin irw = 1'b1; sb = 2'b01; pe = 1'b1; end
                4'd1:  sb = 2'b11;
                4'd2:  begin sa = 1'b1; sb = 2'b10; end
                4'd3:  io = 1'b1;
                4'd4:  begin rw = 1'b1; mr = 1'b1; end
                4'd5:  begin io = 1'b1; mw = 1'b1; end
                4'd6:  begin sa = 1'b1; ac = funct_ctl(f); end
                4'd7:  begin rw = 1'b1; rd = 1'b1; end
                4'd8:  begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = z; end
                4'd9:  begin sa = 1'b1; sb = 2'b10; end
                4'd10: rw = 1'b1;
                4'd11: begin ps = 2'b10; pe = 1'b1; end
                default: ;
            endcase
        end
        return {s, rd, mr, io, sa, sb, ps, ac, irw, mw, rw, pe};
    endfunction

    // One clock: drive inputs just after the edge and queue the expected word.
    task automatic step(input logic rst_v, input logic [3:0] exp_s,
                        input logic [5:0] o, input logic [5:0] f, input int zsel);
        @(posedge clk);
        #1;
        rst_n = rst_v;
        op    = o;
        funct = f;
        zero  = (zsel == 2) ? 1'($urandom) : 1'(zsel);
        sb_q.push_back(exp_word(exp_s, !rst_v, f, zero));
    endtask

    // Run one instruction along its architectural state path; optionally
    // assert reset for rlen cycles starting at path position ridx.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zsel,
                             input int ridx, input int rlen);
        logic [3:0] path[$];
        case (o)
            6'b100011: path = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
            6'b101011: path = {4'd0, 4'd1, 4'd2, 4'd5};
            6'b000000: path = {4'd0, 4'd1, 4'd6, 4'd7};
            6'b000100: path = {4'd0, 4'd1, 4'd8};
            6'b001000: path = {4'd0, 4'd1, 4'd9, 4'd10};
            6'b000010: path = {4'd0, 4'd1, 4'd11};
            default:   path = {4'd0, 4'd1};
        endcase
        for (int i = 0; i < path.size(); i++) begin
            if (i == ridx) begin
                step(1'b0, path[i], o, f, zsel);
                for (int k = 1; k < rlen; k++) step(1'b0, 4'd0, o, f, zsel);
                return;
            end
            // op is don't-care during FETCH, so scramble it there
            step(1'b1, path[i], (i == 0) ? 6'($urandom) : o, f, zsel);
        end
    endtask

    // Monitor: compare every cycle for which an expectation is queued.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            logic [18:0] e, a;
            e = sb_q.pop_front();
            a = {state, regdst, memtoreg, iord, alusrca, alusrcb, pcsrc, alucontrol,
                 irwrite, memwrite, regwrite, pcen};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL ctl_state%0d t=%0t got=%b required=%b", e[18:15], $time, a, e);
            end
        end
    end

    initial begin
        logic [5:0] o, f;
        int kind, ridx, rlen, plen;
        logic [5:0] functs[6];
        functs[0] = 6'b100000; functs[1] = 6'b100010; functs[2] = 6'b100100;
        functs[3] = 6'b100101; functs[4] = 6'b101010; functs[5] = 6'b000111;

        rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0;
        repeat (2) @(posedge clk);
        step(1'b0, 4'd0, 6'd0, 6'd0, 2);

        // Directed: reset held 3 cycles from EXEC, then the named cases.
        run_instr(6'b000000, 6'b100010, 2, 2, 3);
        run_instr(6'b100011, 6'd0,      2, -1, 0);
        run_instr(6'b000000, 6'b100010, 2, -1, 0);
        run_instr(6'b000100, 6'd0,      1, -1, 0);
        run_instr(6'b000100, 6'd0,      0, -1, 0);
        run_instr(6'b101011, 6'd0,      2, -1, 0);
        run_instr(6'b000010, 6'd0,      2, -1, 0);
        run_instr(6'b111111, 6'd0,      2, -1, 0);
        run_instr(6'b001000, 6'd0,      2, -1, 0);

        // Random instruction stream with occasional mid-instruction resets.
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 7);
            case (kind)
                0: o = 6'b100011;
                1: o = 6'b101011;
                2: o = 6'b000000;
                3: o = 6'b000100;
                4: o = 6'b001000;
                5: o = 6'b000010;
                6: o = 6'b111111;
                default: begin
                    o = 6'($urandom);
                    if (o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
                        o == 6'b000100 || o == 6'b001000 || o == 6'b000010)
                        o = 6'b110011;
                end
            endcase
            f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
            case (o)
                6'b100011: plen = 5;
                6'b101011, 6'b000000, 6'b001000: plen = 4;
                6'b000100, 6'b000010: plen = 3;
                default: plen = 2;
            endcase
            ridx = -1; rlen = 0;
            if ($urandom_range(0, 9) == 0) begin
                ridx = $urandom_range(0, plen - 1);
                rlen = $urandom_range(1, 3);
            end
            run_instr(o, f, 2, ridx, rlen);
        end

        // Bounded drain of the scoreboard.
        for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
        #6;
        if (sb_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main controller for the final_core MIPS datapath. It is a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives every datapath select and write enable, including `regdst`, which feeds the register-destination mux directly. It also contains the ALU decoder that turns opcode/funct into the 3-bit ALU control.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock for the whole block.
- `rst_n`  input  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `op`  input  6  instruction[31:26], taken from the instruction register.
- `funct`  input  6  instruction[5:0], taken from the instruction register.
- `zero`  input  1  ALU zero flag (combinational, same cycle).
- `regdst`  output  1  1 selects rd; 0 selects rt.
- `memtoreg`  output  1  1 selects memory data for register writeback; 0 selects ALUOut.
- `iord`  output  1  memory address: 0 = PC, 1 = ALUOut.
- `alusrca`  output  1  ALU A operand: 0 = PC, 1 = register A.
- `alusrcb`  output  2  ALU B operand: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- `pcsrc`  output  2  next-PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol`  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `irwrite`, `memwrite`, `regwrite`, `pcen`  output  1 each  write enables.
- `state`  output  4  current state, for debug and verification.

## Operation
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - EXEC = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11
  - Codes 12–15 are unused; from any of them the next state is FETCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE branches on `op`:
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000000 (R-type) → EXEC.
    - 000100 (beq) → BRANCH.
    - 001000 (addi) → ADDIEX.
    - 000010 (j) → JUMP.
    - Any other opcode → FETCH, with no writes.
  - MEMADR → MEMRD if `op` is lw, otherwise → MEMWR.
  - MEMRD → MEMWB.
  - EXEC → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP → FETCH.
- Outputs are a pure decode of `state`, except `pcen`. Any field not listed for a state is 0.
  - FETCH: `irwrite` = 1, `alusrcb` = 01, `aluop` = add, `pcwrite` = 1.
  - DECODE: `alusrcb` = 11, `aluop` = add.
  - MEMADR: `alusrca` = 1, `alusrcb` = 10, `aluop` = add.
  - MEMRD: `iord` = 1.
  - MEMWB: `regwrite` = 1, `memtoreg` = 1, `regdst` = 0.
  - MEMWR: `iord` = 1, `memwrite` = 1.
  - EXEC: `alusrca` = 1, `alusrcb` = 00, `aluop` = funct.
  - ALUWB: `regwrite` = 1, `regdst` = 1, `memtoreg` = 0.
  - BRANCH: `alusrca` = 1, `alusrcb` = 00, `aluop` = sub, `pcsrc` = 01, `branch` = 1.
  - ADDIEX: `alusrca` = 1, `alusrcb` = 10, `aluop` = add.
  - ADDIWB: `regwrite` = 1, `regdst` = 0, `memtoreg` = 0.
  - JUMP: `pcsrc` = 10, `pcwrite` = 1.
- `pcen` = `pcwrite` | (`branch` & `zero`), evaluated combinationally.
- ALU decoder:
  - `aluop` = add → `alucontrol` 010.
  - `aluop` = sub → `alucontrol` 110.
  - `aluop` = funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111; any other funct → 010.

## Timing
- Reset:
  - `rst_n` = 0 at a rising edge: `state` becomes FETCH.
  - While `rst_n` = 0, `irwrite`, `memwrite`, `regwrite` and `pcen` are forced to 0 combinationally.
  - Every other output carries its FETCH value (`iord` 0, `alusrca` 0, `alusrcb` 01, `pcsrc` 00, `alucontrol` 010, `regdst` 0, `memtoreg` 0).
- Reset asserted in any state overrides the normal transition. The next cycle is FETCH, and no write enable is asserted during that edge.
- State changes only on the rising edge of `clk`. Outputs are valid in the same cycle the state is entered.
- Cycle counts from FETCH through the return to FETCH:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
  - Illegal opcode: 2 cycles.
- `zero` is sampled only in BRANCH. It may toggle in any other state with no effect.
- `op` and `funct` must be stable from DECODE onward. They are ignored in FETCH.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles in the middle of EXEC → `state` = 0; `pcen`, `regwrite`, `memwrite` and `irwrite` all read 0 during reset; after release, FETCH asserts `irwrite` = 1 and `pcen` = 1.
- lw (`op` 100011): `state` sequence 0, 1, 2, 3, 4, 0; in state 4, `regwrite` = 1, `memtoreg` = 1, `regdst` = 0; in state 3, `iord` = 1.
- R-type sub (`op` 0, `funct` 100010): in EXEC, `alucontrol` = 110; in ALUWB, `regwrite` = 1 and `regdst` = 1; 4 cycles total.
- beq with `zero` = 1 then with `zero` = 0: in BRANCH, `pcen` = 1 with `pcsrc` = 01 for the first, and `pcen` = 0 for the second; in both cases `regwrite` = 0 and the next state is FETCH.
- sw and j:
  - sw: MEMWR has `memwrite` = 1 and `iord` = 1; `regwrite` is never asserted.
  - j: JUMP has `pcsrc` = 10 and `pcen` = 1.
- Illegal opcode 111111: `state` goes 0, 1, 0; no write enable other than the FETCH-state `irwrite` and `pcen` is asserted.
